// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   state_e  : FSM state encoding (FETCH/DECODE/EXEC/MEM/WB)
//   OP_*     : instr[31:26] opcode values
//   FN_*     : instr[5:0] funct values for R-type instructions
//   ALU_*    : aluopration encodings seen by the datapath ALU
//   ctrl_t   : every datapath control bundled as one packed word
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       ir_en;
    logic       pc_en;
    logic       selreg;
    logic       regdst;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       pcsrc;
    logic       jal;
    logic       jr;
    logic       jmp;
    logic [2:0] aluop;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // ALU operation for the five arithmetic R-type functs; others map to ADD.
  function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
    logic [2:0] r;
    case (fn)
      FN_SUB:  r = ALU_SUB;
      FN_AND:  r = ALU_AND;
      FN_OR:   r = ALU_OR;
      FN_SLT:  r = ALU_SLT;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between mc_control_fsm and the MIPS datapath.
//   master : control unit side (consumes opcode/opr/zero/mem_ready,
//            drives all datapath controls and status outputs)
//   slave  : datapath / memory side
interface mc_control_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       opr;
  logic             zero;
  logic             mem_ready;
  logic             ir_en;
  logic             pc_en;
  logic             selreg;
  logic             regdst;
  logic             alusrc;
  logic             memread;
  logic             memwrite;
  logic             regwrite;
  logic             memtoreg;
  logic             pcsrc;
  logic             jal;
  logic             jr;
  logic             jmp;
  logic [2:0]       aluopration;
  logic             illegal;
  logic             mem_timeout;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, opr, zero, mem_ready,
    output ir_en, pc_en, selreg, regdst, alusrc, memread, memwrite,
           regwrite, memtoreg, pcsrc, jal, jr, jmp, aluopration,
           illegal, mem_timeout, instret
  );

  modport slave (
    output opcode, opr, zero, mem_ready,
    input  ir_en, pc_en, selreg, regdst, alusrc, memread, memwrite,
           regwrite, memtoreg, pcsrc, jal, jr, jmp, aluopration,
           illegal, mem_timeout, instret
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational control decode for the multi-cycle MIPS control unit.
//   state   : current FSM state
//   opcode  : latched instr[31:26]
//   funct   : latched instr[5:0]
//   zero    : live ALU zero flag (only feeds pcsrc on beq)
//   ctrl    : Moore datapath controls for this state/instruction
//   illegal : high in EXEC for an undecodable instruction
// The MEM-state pc_en (which depends on mem_ready / timeout) is added by
// the top level; here MEM only carries the address-phase controls.
module mc_decode
  import mc_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (state)
      FETCH: ctrl.ir_en = 1'b1;
      DECODE: ;
      EXEC: begin
        ctrl.pc_en = 1'b1;
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = alu_of_funct(funct);
              end
              FN_JR: begin
                ctrl.jmp   = 1'b1;
                ctrl.jr    = 1'b1;
                ctrl.aluop = ALU_ADD;
              end
              default: illegal = 1'b1;
            endcase
          end
          OP_ADDI: begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = ALU_ADD;
          end
          OP_SLTI: begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = ALU_SLT;
          end
          OP_BEQ: begin
            ctrl.aluop = ALU_SUB;
            ctrl.pcsrc = zero;
          end
          OP_J: ctrl.jmp = 1'b1;
          OP_JAL: begin
            ctrl.jmp      = 1'b1;
            ctrl.jal      = 1'b1;
            ctrl.selreg   = 1'b1;
            ctrl.regwrite = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      MEM: begin
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
        ctrl.memread  = (opcode == OP_LW);
        ctrl.memwrite = (opcode == OP_SW);
      end
      WB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
        ctrl.pc_en    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit sitting directly upstream of the MIPS datapath.
// One FSM pass (FETCH -> DECODE -> EXEC | MEM [-> WB]) per instruction.
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   bus (master) : opcode/opr/zero/mem_ready in; all datapath controls,
//                  illegal / mem_timeout pulses and instret count out
// Parameters:
//   MEM_TIMEOUT  : cycles to wait for mem_ready before aborting (>= 1)
//   CNT_W        : retired-instruction counter width
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  mc_control_fsm_if.master   bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [5:0]        fn_q, fn_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  ctrl_t dec_ctrl;
  ctrl_t ctrl;
  ctrl_t ctrl_out;
  logic  dec_illegal;
  logic  timeout_hit;

  mc_decode u_decode (
    .state   (state_q),
    .opcode  (op_q),
    .funct   (fn_q),
    .zero    (bus.zero),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    fn_d        = fn_q;
    wait_d      = wait_q;
    instret_d   = instret_q;
    ctrl        = dec_ctrl;
    timeout_hit = 1'b0;

    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        op_d    = bus.opcode;
        fn_d    = bus.opr;
        // Branch on the live opcode: the latched copy is only valid next cycle.
        state_d = is_mem_op(bus.opcode) ? MEM : EXEC;
      end
      EXEC: state_d = FETCH;
      MEM: begin
        // mem_ready is checked first so it wins over a coincident timeout.
        if (bus.mem_ready) begin
          wait_d = '0;
          if (op_q == OP_LW) begin
            state_d = WB;
          end else begin
            ctrl.pc_en = 1'b1;
            state_d    = FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          // This idle cycle brings the count to MEM_TIMEOUT: abort.
          timeout_hit = 1'b1;
          ctrl.pc_en  = 1'b1;
          wait_d      = '0;
          state_d     = FETCH;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WB: state_d = FETCH;
      default: state_d = FETCH;
    endcase

    if (ctrl.pc_en && !dec_illegal && !timeout_hit) begin
      instret_d = instret_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  // Outputs are forced low while reset is held, so an in-flight memory
  // access is dropped immediately rather than at the next clock.
  always_comb begin
    ctrl_out = rst ? ctrl : '0;
  end

  assign bus.ir_en       = ctrl_out.ir_en;
  assign bus.pc_en       = ctrl_out.pc_en;
  assign bus.selreg      = ctrl_out.selreg;
  assign bus.regdst      = ctrl_out.regdst;
  assign bus.alusrc      = ctrl_out.alusrc;
  assign bus.memread     = ctrl_out.memread;
  assign bus.memwrite    = ctrl_out.memwrite;
  assign bus.regwrite    = ctrl_out.regwrite;
  assign bus.memtoreg    = ctrl_out.memtoreg;
  assign bus.pcsrc       = ctrl_out.pcsrc;
  assign bus.jal         = ctrl_out.jal;
  assign bus.jr          = ctrl_out.jr;
  assign bus.jmp         = ctrl_out.jmp;
  assign bus.aluopration = ctrl_out.aluop;
  assign bus.illegal     = rst & dec_illegal;
  assign bus.mem_timeout = rst & timeout_hit;
  assign bus.instret     = instret_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit directly upstream of the MIPS datapath.
- Consumes the datapath's opcode, opr and zero outputs, and drives every datapath control input.
- Adds PC and IR write enables so the datapath advances one instruction per FSM pass.
- Stalls on a data-memory ready handshake, bounded by a timeout counter, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles to wait for mem_ready before aborting the access.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from datapath.
- opr  in  6  instr[5:0] (funct) from datapath.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  data memory access complete.
- ir_en  out  1  latch instruction register.
- pc_en  out  1  PC write enable.
- selreg, regdst, alusrc, memread, memwrite, regwrite, memtoreg, pcsrc, jal, jr, jmp  out  1 each  datapath controls, same meaning as on the datapath.
- aluopration  out  3  ALU op: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- mem_timeout  out  1  one-cycle pulse on an aborted memory access.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB; encoding is in the package.
- Reset (rst=0, asynchronous):
  - state=FETCH, instret=0, wait counter=0, latched opcode/funct=0.
  - All outputs 0 while reset is held.
  - Reset mid-access drops memread/memwrite immediately.
- FETCH: ir_en=1 for one cycle -> DECODE.
- DECODE:
  - Latch opcode/opr into internal registers; all later decoding uses the latched copies.
  - lw/sw -> MEM; anything else -> EXEC.
- Decode table:
  - R-type (op 0x00), funct 0x20 add / 0x22 sub / 0x24 and / 0x25 or / 0x2A slt: regdst=1, alusrc=0, regwrite=1.
  - jr: op 0x00, funct 0x08.
  - Other opcodes: addi 0x08, slti 0x0A, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
- EXEC, one cycle; pc_en=1 always:
  - R-type ALU: as in the decode table; aluopration from funct.
  - addi/slti: alusrc=1, regdst=0, regwrite=1; ADD or SLT.
  - beq: aluopration=SUB, pcsrc=zero (sampled combinationally this cycle).
  - j: jmp=1.
  - jal: jmp=1, jal=1, selreg=1, regwrite=1.
  - jr: jmp=1, jr=1, aluopration=ADD, alusrc=0. Register rt must read $0; this is the programmer's responsibility.
  - Illegal opcode or funct: no writes, pc_en=1 (NOP), illegal=1.
  - Next state: FETCH.
- MEM (lw/sw):
  - Asserted for every MEM cycle: alusrc=1, aluopration=ADD, and memread (lw) or memwrite (sw).
  - The wait counter increments each cycle mem_ready=0.
  - mem_ready=1 on a lw: -> WB.
  - mem_ready=1 on a sw: pc_en=1 this cycle -> FETCH.
  - Counter reaching MEM_TIMEOUT with mem_ready=0: mem_timeout=1, pc_en=1, no register write, not retired -> FETCH.
  - mem_ready and timeout in the same cycle: ready wins.
  - The counter clears on leaving MEM.
- WB (lw): memtoreg=1, regwrite=1, regdst=0, alusrc=1, aluopration=ADD, pc_en=1 -> FETCH.
- instret:
  - Increments on every pc_en cycle, excluding illegal and timeout cycles.
  - Wraps modulo 2^CNT_W with no saturation.
- Latency in cycles: R/I/branch/jump = 3; sw = 3 + wait; lw = 4 + wait.
- In FETCH and DECODE every control except ir_en is 0. Controls are Moore outputs of state + latched opcode, except pcsrc, which uses live zero.

Decomposition:
- Package mc_pkg holds:
  - state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J, OP_JAL);
  - funct constants;
  - ALU op constants;
  - packed struct ctrl_t bundling all datapath controls.
- One combinational sub-module, mc_decode: (state, opcode, funct, zero) -> ctrl_t + illegal.
- The FSM, wait counter and instret counter stay in the top module.

Test Plan:
- Reset held low 3 cycles with opcode=0x23, mem_ready=1 -> all outputs 0, instret=0; first cycle after release: ir_en=1.
- add (op 0x00, funct 0x20) -> ir_en on cycle 1; cycle 3: regdst=1, regwrite=1, aluopration=010, pc_en=1; instret=1.
- beq with zero=1, then beq with zero=0 -> EXEC pcsrc=1 then pcsrc=0; aluopration=110 in both.
- lw with mem_ready low 5 cycles -> memread=1 for 6 cycles, then WB with memtoreg=1, regwrite=1, pc_en=1; total 9 cycles.
- sw with MEM_TIMEOUT=4, mem_ready=0 -> memwrite for 4 cycles, mem_timeout pulse, pc_en=1, instret unchanged, back to FETCH.
- jal, then op 0x3F -> jal: jmp=1, jal=1, selreg=1, regwrite=1; op 0x3F: illegal pulse, pc_en=1, regwrite=0, instret unchanged.
